// File: rtl/alarm_defs.sv
`default_nettype none
// ============================================================================
//  Package     : alarm_defs
//  Description : Shared FSM state encoding and alarm source indices for the
//                household alarm scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_defs;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        SOUND    = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    // Alarm source indices; a lower index means a higher priority
    localparam int SRC_FIRE  = 0;
    localparam int SRC_DOOR  = 1;
    localparam int SRC_WATER = 2;
    localparam int SRC_RAIN  = 3;
    localparam int SRC_WIN0  = 4;
    localparam int SRC_WIN1  = 5;
    localparam int SRC_WIN2  = 6;
    localparam int SRC_WIN3  = 7;

endpackage : alarm_defs
`default_nettype wire

// File: rtl/alarm_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_prio_enc
//  Description : Lowest-index-first priority encoder. idx is the lowest set
//                bit of req; any flags that at least one bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_prio_enc #(
    parameter int N_SRC  = 8,
    parameter int CODE_W = 3
) (
    input  logic [N_SRC-1:0]  req,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = CODE_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : alarm_prio_enc
`default_nettype wire

// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_scheduler
//  Description : Shares one notifier channel and siren among N_SRC alarm
//                sources. Rising edges of unmasked alarms set sticky pending
//                bits, which are served lowest index first: notify, sound the
//                siren for HOLD_CYCLES, then hold the siren until user ack.
//                Higher-priority arrivals preempt; masking the served source
//                aborts service.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_scheduler
    import alarm_defs::*;
#(
    parameter int N_SRC       = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int CODE_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  alarm_in,
    input  logic [N_SRC-1:0]  mask,
    input  logic              ack,
    input  logic              notif_ready,
    output logic              notif_valid,
    output logic [CODE_W-1:0] notif_code,
    output logic              siren,
    output logic [N_SRC-1:0]  pending,
    output logic              busy
);

    localparam int                C_HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [C_HC_W-1:0] C_HOLD_INIT = C_HC_W'(HOLD_CYCLES - 1);

    // Registered state
    state_t              r_state;
    logic [N_SRC-1:0]    r_pending;
    logic [N_SRC-1:0]    r_alarm_d;
    logic [CODE_W-1:0]   r_cur;
    logic                r_notif_valid;
    logic                r_siren;
    logic [C_HC_W-1:0]   r_hold_cnt;

    // Next-state values
    state_t              w_state_nx;
    logic [CODE_W-1:0]   w_cur_nx;
    logic                w_valid_nx;
    logic                w_siren_nx;
    logic [C_HC_W-1:0]   w_hold_nx;

    // Capture / selection helpers
    logic [N_SRC-1:0]    w_rise;
    logic [N_SRC-1:0]    w_cur_onehot;
    logic [N_SRC-1:0]    w_lower;
    logic [N_SRC-1:0]    w_clr;
    logic [N_SRC-1:0]    w_pending_nx;
    logic                w_cur_masked;
    logic                w_ack_take;
    logic [CODE_W-1:0]   w_sel_idx;
    logic                w_sel_any;
    logic [CODE_W-1:0]   w_pre_idx;
    logic                w_pre_any;

    assign w_rise       = alarm_in & ~r_alarm_d & ~mask;
    assign w_cur_onehot = N_SRC'(1) << r_cur;
    assign w_cur_masked = |(mask & w_cur_onehot);

    // Bits strictly below the source currently being served
    always_comb begin
        w_lower = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_lower[i] = (i < int'(r_cur));
        end
    end

    // Any pending source that outranks the current one triggers preemption
    alarm_prio_enc #(
        .N_SRC  (N_SRC),
        .CODE_W (CODE_W)
    ) u_pre_enc (
        .req (r_pending & w_lower),
        .idx (w_pre_idx),
        .any (w_pre_any)
    );

    // Ack only retires the served source when neither abort nor preempt wins
    assign w_ack_take = (r_state == WAIT_ACK) && ack && !w_cur_masked && !w_pre_any;
    assign w_clr      = w_ack_take ? w_cur_onehot : '0;

    // Selecting from pending with the acked bit removed lets the next source
    // be chosen in the very cycle the ack retires the current one
    alarm_prio_enc #(
        .N_SRC  (N_SRC),
        .CODE_W (CODE_W)
    ) u_sel_enc (
        .req (r_pending & ~w_clr),
        .idx (w_sel_idx),
        .any (w_sel_any)
    );

    // A new edge on the acked bit survives the clear, so it is served again
    assign w_pending_nx = ((r_pending & ~w_clr) | w_rise) & ~mask;

    // Next-state and output decode for the service FSM
    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur;
        w_valid_nx = r_notif_valid;
        w_siren_nx = r_siren;
        w_hold_nx  = r_hold_cnt;
        if ((r_state != IDLE) && w_cur_masked) begin
            // Served source was masked: drop everything, including a transfer
            w_state_nx = IDLE;
            w_valid_nx = 1'b0;
            w_siren_nx = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_any) begin
                        w_state_nx = SEND;
                        w_cur_nx   = w_sel_idx;
                        w_valid_nx = 1'b1;
                        w_siren_nx = 1'b0;
                    end
                end
                SEND: begin
                    if (notif_ready) begin
                        w_state_nx = SOUND;
                        w_valid_nx = 1'b0;
                        w_siren_nx = 1'b1;
                        w_hold_nx  = C_HOLD_INIT;
                    end
                end
                SOUND, WAIT_ACK: begin
                    if (w_pre_any) begin
                        w_state_nx = SEND;
                        w_cur_nx   = w_pre_idx;
                        w_valid_nx = 1'b1;
                        w_siren_nx = 1'b0;
                    end else if (r_state == SOUND) begin
                        if (r_hold_cnt == '0) begin
                            w_state_nx = WAIT_ACK;
                        end else begin
                            w_hold_nx = r_hold_cnt - 1'b1;
                        end
                    end else if (ack) begin
                        w_siren_nx = 1'b0;
                        if (w_sel_any) begin
                            w_state_nx = SEND;
                            w_cur_nx   = w_sel_idx;
                            w_valid_nx = 1'b1;
                        end else begin
                            w_state_nx = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_valid_nx = 1'b0;
                    w_siren_nx = 1'b0;
                end
            endcase
        end
    end

    // State, capture and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pending     <= '0;
            r_alarm_d     <= '0;
            r_cur         <= '0;
            r_notif_valid <= 1'b0;
            r_siren       <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_pending     <= w_pending_nx;
            r_alarm_d     <= alarm_in;
            r_cur         <= w_cur_nx;
            r_notif_valid <= w_valid_nx;
            r_siren       <= w_siren_nx;
            r_hold_cnt    <= w_hold_nx;
        end
    end

    assign notif_valid = r_notif_valid;
    assign notif_code  = r_cur;
    assign siren       = r_siren;
    assign pending     = r_pending;
    assign busy        = (r_state != IDLE);

endmodule : alarm_scheduler
`default_nettype wire
